// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared op codes, field slices, command words and FSM states
package stepper_pkg;

   localparam logic [1:0] OP_MOVE = 2'b00;
   localparam logic [1:0] OP_HOLD = 2'b01;
   localparam logic [1:0] OP_HOME = 2'b11;

   localparam int OP_MSB = 22;
   localparam int OP_LSB = 21;
   localparam int POS_W  = 21;

   localparam logic [31:0] HOLD_WORD      = {9'b0, OP_HOLD, {POS_W{1'b0}}};
   localparam logic [31:0] ZERO_MOVE_WORD = {9'b0, OP_MOVE, {POS_W{1'b0}}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_RUN,
      ST_SETTLE,
      ST_HOME
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock command FIFO with occupancy count and flush
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // A full FIFO still takes a push when the same cycle frees a slot.
   always_comb begin
      do_pop   = pop && !empty && !flush;
      do_push  = push && (!full || do_pop) && !flush;
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/stepper_cmd_sequencer.sv
// rtl/stepper_cmd_sequencer.sv - queues CPU motion commands and issues them to the stepper
module stepper_cmd_sequencer
   import stepper_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int START_TO   = 16,
   parameter int SETTLE_CYC = 1000000,
   parameter int HOME_CYC   = 1000
) (
   input  logic                      CLK100MHZ,
   input  logic                      CPU_RESETN,
   input  logic [31:0]               cmd_data,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      abort,
   output logic [31:0]               stp_data,
   output logic                      stp_new,
   input  logic                      stp_busy,
   output logic                      seq_busy,
   output logic                      done,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic [7:0]                null_moves
);

   localparam int TW = $clog2(max3(START_TO, SETTLE_CYC, HOME_CYC) + 1);
   localparam logic [TW-1:0] START_LAST  = TW'(START_TO - 1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] HOME_LAST   = TW'(HOME_CYC - 1);

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [31:0]   stp_data_q, stp_data_d;
   logic          stp_new_q, stp_new_d;
   logic          done_q, done_d;
   logic [7:0]    null_q, null_d;
   logic          abort_q, abort_d;

   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [31:0]   fifo_rdata;

   assign cmd_ready = !fifo_full;
   assign fifo_push = cmd_valid && cmd_ready && !abort;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .flush (abort),
      .push  (fifo_push),
      .wdata (cmd_data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q + 1'b1;
      stp_data_d = stp_data_q;
      stp_new_d  = 1'b0;
      done_d     = 1'b0;
      null_d     = null_q;
      fifo_pop   = 1'b0;
      abort_d    = abort;

      if (abort) begin
         // Only the rising cycle of abort reloads the stepper; holding it stays quiet.
         state_d = ST_IDLE;
         if (!abort_q) begin
            stp_data_d = HOLD_WORD;
            stp_new_d  = 1'b1;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  stp_data_d = fifo_rdata;
                  stp_new_d  = 1'b1;
                  state_d    = (fifo_rdata[OP_MSB:OP_LSB] == OP_HOME) ? ST_HOME : ST_START;
               end
            end
            ST_START: begin
               if (stp_busy) begin
                  state_d = ST_RUN;
               end else if (timer_q == START_LAST) begin
                  state_d = ST_SETTLE;
                  if (null_q != 8'hFF) null_d = null_q + 8'd1;
               end
            end
            ST_RUN: begin
               if (!stp_busy) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (timer_q == SETTLE_LAST) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_HOME: begin
               if (timer_q == HOME_LAST) begin
                  stp_data_d = ZERO_MOVE_WORD;
                  stp_new_d  = 1'b1;
                  state_d    = ST_START;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (state_d != state_q || state_q == ST_IDLE || state_q == ST_RUN) timer_d = '0;
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         stp_data_q <= HOLD_WORD;
         stp_new_q  <= 1'b0;
         done_q     <= 1'b0;
         null_q     <= 8'd0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         stp_data_q <= stp_data_d;
         stp_new_q  <= stp_new_d;
         done_q     <= done_d;
         null_q     <= null_d;
         abort_q    <= abort_d;
      end
   end

   assign stp_data   = stp_data_q;
   assign stp_new    = stp_new_q;
   assign done       = done_q;
   assign null_moves = null_q;
   assign seq_busy   = (state_q != ST_IDLE) || !fifo_empty;

endmodule
